// File: rtl/spi_fsm.sv
// Sequencing FSM for the SPI slave: counts address/data bits from conditioned
// sclk edge pulses and steers the address latch, data memory and MISO strobes.
module spi_fsm #(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic cs,
    input  logic sclk_pos,
    input  logic sclk_neg,
    input  logic rw_bit,
    output logic addr_we,
    output logic dm_we,
    output logic sr_we,
    output logic miso_buff,
    output logic xfer_done
);

    localparam int ADDR_LEN = ADDR_BITS + 1;
    localparam int MAX_LEN  = (ADDR_LEN > DATA_BITS) ? ADDR_LEN : DATA_BITS;
    localparam int CNT_W    = $clog2(MAX_LEN + 1);

    // The pulse arriving while the count equals LEN-1 is the one that completes the phase.
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GOT_ADDR,
        READ_LOAD,
        READ_SEND,
        WRITE_GET,
        WRITE_STORE,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        case (state_q)
            IDLE: begin
                if (!cs) state_d = GET_ADDR;
            end
            GET_ADDR: begin
                if (sclk_pos) begin
                    if (bitcnt_q == ADDR_LAST) state_d = GOT_ADDR;
                    else bitcnt_d = bitcnt_q + CNT_W'(1);
                end
            end
            GOT_ADDR: begin
                state_d = rw_bit ? READ_LOAD : WRITE_GET;
            end
            READ_LOAD: begin
                state_d = READ_SEND;
            end
            READ_SEND: begin
                if (sclk_neg) begin
                    if (bitcnt_q == DATA_LAST) state_d = DONE;
                    else bitcnt_d = bitcnt_q + CNT_W'(1);
                end
            end
            WRITE_GET: begin
                if (sclk_pos) begin
                    if (bitcnt_q == DATA_LAST) state_d = WRITE_STORE;
                    else bitcnt_d = bitcnt_q + CNT_W'(1);
                end
            end
            WRITE_STORE: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Deasserted chip select aborts any frame and is also the normal exit from DONE.
        if (cs && (state_q != IDLE)) state_d = IDLE;
        if (state_d != state_q) bitcnt_d = '0;
    end

    // Strobes are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            addr_we   <= 1'b0;
            dm_we     <= 1'b0;
            sr_we     <= 1'b0;
            miso_buff <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            addr_we   <= (state_d == GOT_ADDR);
            dm_we     <= (state_d == WRITE_STORE);
            sr_we     <= (state_d == READ_LOAD);
            miso_buff <= (state_d == READ_SEND);
            xfer_done <= (state_d == DONE) && (state_q != DONE);
        end
    end

endmodule

// File: tb/tb_spi_fsm.sv
// Directed bench for spi_fsm: reset, write/read frames, abort, noise and
// back-to-back frames, with hand-derived strobe timing.
module tb_spi_fsm;

    logic clk = 1'b0;
    logic reset;
    logic cs;
    logic sclk_pos;
    logic sclk_neg;
    logic rw_bit;
    logic addr_we;
    logic dm_we;
    logic sr_we;
    logic miso_buff;
    logic xfer_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle strobe counts, sampled mid-cycle.
    int cnt_addr = 0;
    int cnt_dm   = 0;
    int cnt_sr   = 0;
    int cnt_miso = 0;
    int cnt_xfer = 0;

    spi_fsm #(.ADDR_BITS(7), .DATA_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .sclk_pos  (sclk_pos),
        .sclk_neg  (sclk_neg),
        .rw_bit    (rw_bit),
        .addr_we   (addr_we),
        .dm_we     (dm_we),
        .sr_we     (sr_we),
        .miso_buff (miso_buff),
        .xfer_done (xfer_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (addr_we)   cnt_addr++;
        if (dm_we)     cnt_dm++;
        if (sr_we)     cnt_sr++;
        if (miso_buff) cnt_miso++;
        if (xfer_done) cnt_xfer++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clk cycle with the given inputs; returns 1 time unit after the sampling edge.
    task automatic cyc(input logic c, input logic p, input logic n);
        cs       = c;
        sclk_pos = p;
        sclk_neg = n;
        @(posedge clk);
        #1;
    endtask

    // Expected vector order: {addr_we, dm_we, sr_we, miso_buff, xfer_done}
    task automatic chk_outs(input string tag, input logic [4:0] exp);
        check_eq(tag, {27'd0, addr_we, dm_we, sr_we, miso_buff, xfer_done}, {27'd0, exp});
    endtask

    task automatic run_frame(input logic rw, input string tag);
        int a0;
        int d0;
        int s0;
        int m0;
        int x0;
        a0 = cnt_addr; d0 = cnt_dm; s0 = cnt_sr; m0 = cnt_miso; x0 = cnt_xfer;
        rw_bit = rw;
        cyc(1'b0, 1'b0, 1'b0);
        chk_outs({tag, "_enter"}, 5'b00000);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            check_eq({tag, "_addr_we"}, {31'd0, addr_we}, (i == 7) ? 32'd1 : 32'd0);
        end
        if (rw) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk_outs({tag, "_load"}, 5'b00100);
            cyc(1'b0, 1'b0, 1'b0);
            chk_outs({tag, "_send"}, 5'b00010);
            for (int i = 0; i < 8; i++) begin
                cyc(1'b0, 1'b0, 1'b1);
                chk_outs({tag, "_rdbit"}, (i == 7) ? 5'b00001 : 5'b00010);
            end
        end else begin
            cyc(1'b0, 1'b0, 1'b0);
            chk_outs({tag, "_wget"}, 5'b00000);
            for (int i = 0; i < 8; i++) begin
                cyc(1'b0, 1'b1, 1'b0);
                chk_outs({tag, "_wrbit"}, (i == 7) ? 5'b01000 : 5'b00000);
            end
            cyc(1'b0, 1'b0, 1'b0);
            chk_outs({tag, "_wdone"}, 5'b00001);
        end
        cyc(1'b0, 1'b0, 1'b0);
        chk_outs({tag, "_hold"}, 5'b00000);
        cyc(1'b1, 1'b0, 1'b0);
        chk_outs({tag, "_idle"}, 5'b00000);
        check_eq({tag, "_n_addr"}, cnt_addr - a0, 32'd1);
        check_eq({tag, "_n_dm"},   cnt_dm - d0,   rw ? 32'd0 : 32'd1);
        check_eq({tag, "_n_sr"},   cnt_sr - s0,   rw ? 32'd1 : 32'd0);
        check_eq({tag, "_n_miso"}, cnt_miso - m0, rw ? 32'd8 : 32'd0);
        check_eq({tag, "_n_xfer"}, cnt_xfer - x0, 32'd1);
        $display("frame %s rw=%0b complete", tag, rw);
    endtask

    initial begin
        int d0;
        int x0;
        int a0;
        reset    = 1'b1;
        cs       = 1'b0;
        sclk_pos = 1'b1;
        sclk_neg = 1'b1;
        rw_bit   = 1'b0;

        // Reset state, with activity on every input
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk_outs("reset_outs", 5'b00000);
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0);
        chk_outs("post_reset_idle", 5'b00000);
        $display("reset applied and released");

        // Reset mid-GET_ADDR: the count must restart from zero
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 1'b0);
        chk_outs("midreset_outs", 5'b00000);
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            check_eq("midreset_addr_we", {31'd0, addr_we}, (i == 7) ? 32'd1 : 32'd0);
        end
        rw_bit = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk_outs("midreset_abort", 5'b00000);
        $display("mid-address reset transaction done");

        run_frame(1'b0, "write");
        run_frame(1'b1, "read");

        // Abort after 5 data bits of a write
        d0 = cnt_dm; x0 = cnt_xfer;
        rw_bit = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk_outs("abort_idle", 5'b00000);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0);
        check_eq("abort_n_dm",   cnt_dm - d0,   32'd0);
        check_eq("abort_n_xfer", cnt_xfer - x0, 32'd0);
        $display("abort transaction done");
        run_frame(1'b0, "after_abort");

        // Noise: sclk_neg in GET_ADDR, a simultaneous pulse pair, sclk_pos in DONE
        a0 = cnt_addr; x0 = cnt_xfer;
        rw_bit = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i < 3) cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b1, (i == 4) ? 1'b1 : 1'b0);
            check_eq("noise_addr_we", {31'd0, addr_we}, (i == 7) ? 32'd1 : 32'd0);
        end
        cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0);
        chk_outs("noise_store", 5'b01000);
        cyc(1'b0, 1'b0, 1'b0);
        chk_outs("noise_done", 5'b00001);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0);
        chk_outs("noise_in_done", 5'b00000);
        check_eq("noise_n_addr", cnt_addr - a0, 32'd1);
        check_eq("noise_n_xfer", cnt_xfer - x0, 32'd1);
        cyc(1'b1, 1'b0, 1'b0);
        $display("noise transaction done");

        // Back-to-back writes with a single cycle of cs high between them
        d0 = cnt_dm; x0 = cnt_xfer;
        run_frame(1'b0, "b2b_a");
        run_frame(1'b0, "b2b_b");
        check_eq("b2b_n_dm",   cnt_dm - d0,   32'd2);
        check_eq("b2b_n_xfer", cnt_xfer - x0, 32'd2);

        cyc(1'b1, 1'b0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_fsm.md
# spi_fsm

Synchronous sequencing FSM for the SPI slave peripheral. It takes the conditioned chip-select and the sclk edge pulses from the input conditioners and counts address and data bits. It steers the write enables of the address latch, the data memory, the MISO shift-register parallel load and the MISO tri-state buffer. It sits between the input conditioners and the shift-register/data-memory datapath and has no data path of its own.

## Interface
- `ADDR_BITS`, default 7: address bits per frame; the address phase is `ADDR_BITS+1` bits, with the last bit being R/W.
- `DATA_BITS`, default 8: data bits per frame.

- `clk`  in  1  system clock; all state updates on its posedge.
- `reset`  in  1  synchronous, active-high reset.
- `cs`  in  1  conditioned chip select, active low.
- `sclk_pos`  in  1  one-`clk` pulse per sclk rising edge, from the conditioner.
- `sclk_neg`  in  1  one-`clk` pulse per sclk falling edge, from the conditioner.
- `rw_bit`  in  1  bit 0 of the MOSI shift-register parallel output; 1 = read, 0 = write.
- `addr_we`  out  1  address latch write enable.
- `dm_we`  out  1  data memory write enable.
- `sr_we`  out  1  MISO shift-register parallel load.
- `miso_buff`  out  1  MISO tri-state driver enable.
- `xfer_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- States: IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SEND, WRITE_GET, WRITE_STORE, DONE.
- `bitcnt` is `$clog2(max(ADDR_BITS+1, DATA_BITS)+1)` bits wide.
  - Cleared on every state change.
  - Increments only on the qualifying edge pulse of the current state.
- IDLE: when `cs`=0, go to GET_ADDR.
- GET_ADDR:
  - Count `sclk_pos`.
  - On the pulse that makes `bitcnt` = `ADDR_BITS+1`, go to GOT_ADDR.
- GOT_ADDR: single cycle. Next state is READ_LOAD if `rw_bit`=1, else WRITE_GET.
- READ_LOAD: single cycle, then READ_SEND.
- READ_SEND:
  - Count `sclk_neg`.
  - On the pulse that makes `bitcnt` = `DATA_BITS`, go to DONE.
- WRITE_GET:
  - Count `sclk_pos`.
  - On the pulse that makes `bitcnt` = `DATA_BITS`, go to WRITE_STORE.
- WRITE_STORE: single cycle, then DONE.
- DONE: hold until `cs`=1, then go to IDLE.
- Outputs are Moore decodes of the state register:
  - `addr_we`=1 only in GOT_ADDR.
  - `sr_we`=1 only in READ_LOAD.
  - `miso_buff`=1 only in READ_SEND.
  - `dm_we`=1 only in WRITE_STORE.
- `xfer_done` is registered and high for exactly the first cycle in DONE.
- Abort: `cs`=1 sampled in any state other than IDLE forces the next state to IDLE with `bitcnt` cleared.
  - Abort takes priority over every other transition.
  - A strobe already asserted by the current state still completes its single cycle.
  - No strobe that has not yet been reached is issued.
  - An abort from DONE is the normal exit.
- Simultaneous `sclk_pos` and `sclk_neg` (illegal from the conditioner): each pulse is honoured only in the states that count it.
- Edge pulses in single-cycle states and in IDLE/DONE are ignored and not carried over.

## Timing
- Reset: state=IDLE, `bitcnt`=0, all outputs 0. It takes effect on the first `clk` posedge with `reset`=1, regardless of state.
- `cs` falling: GET_ADDR is entered 1 cycle after `cs`=0 is sampled.
- `addr_we` rises 1 cycle after the posedge that samples the final address `sclk_pos`. `rw_bit` is sampled in that same GOT_ADDR cycle.
- Read path:
  - GOT_ADDR is 1 cycle, then READ_LOAD (`sr_we`) is 1 cycle.
  - `miso_buff` therefore rises 2 cycles after `addr_we`.
  - `miso_buff` drops 1 cycle after the `DATA_BITS`-th `sclk_neg` is sampled.
- Write path:
  - `dm_we` rises 1 cycle after the `DATA_BITS`-th `sclk_pos` is sampled.
  - `dm_we` is high for exactly 1 cycle.
- `xfer_done` is high the cycle after the last data strobe state (WRITE_STORE) or after READ_SEND exits.
- Back-to-back frames need `cs` high for at least 1 sampled cycle to pass through IDLE.

## Test plan
- Reset mid-GET_ADDR after 3 `sclk_pos`, then release, then `cs`=0 -> outputs 0 during reset; the count restarts, so 8 more `sclk_pos` are needed before `addr_we`.
- Write frame, `cs`=0, 8 `sclk_pos` with `rw_bit`=0, then 8 `sclk_pos` -> `addr_we` 1 cycle; `dm_we` 1 cycle, 1 cycle after pulse 16; `xfer_done` on the next cycle; `sr_we` and `miso_buff` never high.
- Read frame, 8 `sclk_pos` with `rw_bit`=1, then 8 `sclk_neg` ->
  - `addr_we`, then `sr_we`, on consecutive cycles;
  - `miso_buff` high from 2 cycles after `addr_we` until 1 cycle after the 8th `sclk_neg`;
  - `dm_we` never high.
- Abort, `cs`=1 after 5 data `sclk_pos` of a write -> IDLE next cycle; `dm_we` and `xfer_done` stay 0; a following full frame behaves normally.
- Noise, 3 `sclk_neg` during GET_ADDR and extra `sclk_pos` in DONE -> `bitcnt` unaffected, no extra strobes, and the FSM stays in DONE until `cs`=1.
- Back-to-back, two write frames separated by a single cycle of `cs`=1 -> two `dm_we` pulses and two `xfer_done` pulses.
